// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: exception codes,
// enable levels, default redirect vectors and the flush FSM state type.
package pipe_ctrl_pkg;

    // Exception codes as delivered by the mem stage
    localparam logic [31:0] EXC_INTERRUPT    = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
    localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_OV           = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic        STOP       = 1'b1;
    localparam logic        RST_ENABLE = 1'b1;

    // Default redirect targets
    localparam logic [31:0] DEF_INT_VEC = 32'h0000_0020;
    localparam logic [31:0] DEF_EXC_VEC = 32'h0000_0040;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_e;

endpackage

// File: rtl/pipe_ctrl_vec.sv
// Redirect target decode: maps an exception code (and the EPC for eret)
// onto the PC the pipeline must restart from. Purely combinational.
module pipe_ctrl_vec
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] INT_VEC = DEF_INT_VEC,
    parameter logic [31:0] EXC_VEC = DEF_EXC_VEC
) (
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [31:0] vec_o
);

    // Interrupts and eret have dedicated targets; every other code traps to EXC_VEC
    always_comb begin
        vec_o = EXC_VEC;
        case (excepttype_i)
            EXC_INTERRUPT: vec_o = INT_VEC;
            EXC_ERET:      vec_o = cp0_epc_i;
            EXC_SYSCALL, EXC_INST_INVALID, EXC_OV, EXC_TRAP: vec_o = EXC_VEC;
            default:       vec_o = EXC_VEC;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: deepest-stall-wins merge of stall requests,
// multi-cycle exception flush sequencing with redirect target, stall
// watchdog and a saturating stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int                 STAGES        = 6,
    parameter int                 NSRC          = 4,
    parameter int                 DW            = 3,
    parameter logic [NSRC*DW-1:0] SRC_DEPTH     = {3'd2, 3'd4, 3'd3, 3'd2},
    parameter int                 FLUSH_LEN     = 1,
    parameter logic [31:0]        INT_VEC       = DEF_INT_VEC,
    parameter logic [31:0]        EXC_VEC       = DEF_EXC_VEC,
    parameter int                 STALL_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   stall_req_i,
    input  logic [31:0]       excepttype_i,
    input  logic [31:0]       cp0_epc_i,
    input  logic              perf_clr_i,
    output logic [STAGES-1:0] stall_o,
    output logic              flush_o,
    output logic [31:0]       new_pc_o,
    output logic              stall_timeout_o,
    output logic [31:0]       stall_cycles_o
);

    localparam int FCW = $clog2(FLUSH_LEN + 1);

    flush_state_e             state_q, state_d;
    logic [FCW-1:0]           fcnt_q, fcnt_d;
    logic [31:0]              pc_hold_q, pc_hold_d;
    logic [31:0]              stall_cycles_q, stall_cycles_d;

    logic [NSRC-1:0][STAGES-1:0] src_mask;
    logic [STAGES-1:0]           stall_resolved;
    logic [31:0]                 exc_vec;
    logic                        exc_now;

    // Each requesting source stalls stages 0..depth
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        localparam int DEPTH = int'(SRC_DEPTH[gi*DW +: DW]);
        for (genvar gj = 0; gj < STAGES; gj++) begin : g_bit
            assign src_mask[gi][gj] = (stall_req_i[gi] == STOP) && (gj <= DEPTH);
        end
    end

    // OR of all masks equals the mask of the deepest requester
    always_comb begin
        stall_resolved = '0;
        for (int i = 0; i < NSRC; i++) begin
            stall_resolved = stall_resolved | src_mask[i];
        end
    end

    pipe_ctrl_vec #(
        .INT_VEC (INT_VEC),
        .EXC_VEC (EXC_VEC)
    ) u_vec (
        .excepttype_i (excepttype_i),
        .cp0_epc_i    (cp0_epc_i),
        .vec_o        (exc_vec)
    );

    // A new exception is only accepted in RUN; during FLUSH the inputs come from flushed instructions
    assign exc_now = (state_q == ST_RUN) && (excepttype_i != ZERO_WORD);

    // Flush FSM state, flush counter, held target and perf counter registers
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q        <= ST_RUN;
            fcnt_q         <= '0;
            pc_hold_q      <= ZERO_WORD;
            stall_cycles_q <= ZERO_WORD;
        end else begin
            state_q        <= state_d;
            fcnt_q         <= fcnt_d;
            pc_hold_q      <= pc_hold_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Flush FSM next state: enter FLUSH for the remaining FLUSH_LEN-1 cycles
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        pc_hold_d = pc_hold_q;
        case (state_q)
            ST_RUN: begin
                if (exc_now) begin
                    pc_hold_d = exc_vec;
                    if (FLUSH_LEN > 1) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FCW'(FLUSH_LEN - 1);
                    end
                end
            end
            ST_FLUSH: begin
                fcnt_d = fcnt_q - 1'b1;
                if (fcnt_q <= FCW'(1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                fcnt_d  = '0;
            end
        endcase
    end

    // Outputs: flush overrides stalls; everything is quiet while reset is held
    always_comb begin
        stall_o  = '0;
        flush_o  = 1'b0;
        new_pc_o = ZERO_WORD;
        if (rst != RST_ENABLE) begin
            if (state_q == ST_FLUSH) begin
                flush_o  = 1'b1;
                new_pc_o = pc_hold_q;
            end else if (exc_now) begin
                flush_o  = 1'b1;
                new_pc_o = exc_vec;
            end else begin
                stall_o  = stall_resolved;
            end
        end
    end

    // Saturating stall-cycle counter; clear beats increment
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (perf_clr_i) begin
            stall_cycles_d = ZERO_WORD;
        end else if (stall_o[0] && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cycles_q;

    if (STALL_TIMEOUT > 0) begin : g_wdog
        localparam int SCW = $clog2(STALL_TIMEOUT + 1);
        localparam logic [SCW-1:0] TO_MAX = SCW'(STALL_TIMEOUT);

        logic [SCW-1:0] scnt_q, scnt_d;
        logic           timeout_q, timeout_d;
        logic           stall_any;

        assign stall_any = |stall_o;

        // Watchdog registers
        always_ff @(posedge clk) begin
            if (rst == RST_ENABLE) begin
                scnt_q    <= '0;
                timeout_q <= 1'b0;
            end else begin
                scnt_q    <= scnt_d;
                timeout_q <= timeout_d;
            end
        end

        // Count consecutive stalled cycles, saturating; flag once the limit is reached
        always_comb begin
            scnt_d = '0;
            if (stall_any) begin
                scnt_d = (scnt_q == TO_MAX) ? scnt_q : scnt_q + 1'b1;
            end
            timeout_d = stall_any && (scnt_d == TO_MAX);
        end

        assign stall_timeout_o = timeout_q;
    end else begin : g_no_wdog
        assign stall_timeout_o = 1'b0;
    end

endmodule
